// File: rtl/pulse_buffer_writer_if.sv
// Pulse-event input and BRAM write port of the photon pulse buffer writer.
// The writer takes the slave side; the pulse source and BRAM take the master side.
interface pulse_buffer_writer_if #(
   parameter int ADDR_W = 12
);
   logic              pulse_valid;
   logic [8:0]        pulse_chan;
   logic [9:0]        pulse_ts;
   logic [11:0]       pulse_phase;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [31:0]       bram_din;

   modport master (
      output pulse_valid, pulse_chan, pulse_ts, pulse_phase,
      input  bram_we, bram_addr, bram_din
   );

   modport slave (
      input  pulse_valid, pulse_chan, pulse_ts, pulse_phase,
      output bram_we, bram_addr, bram_din
   );
endinterface

// File: rtl/pulse_buffer_writer.sv
// Packs photon pulse events into 32-bit words and writes them into a ping-pong BRAM,
// inserting a frame header as the first word of every buffer half.
//
// state  | meaning
// ST_OFF | capture disabled, FIFO held empty, pointer frozen
// ST_HDR | header owed at wr_ptr (start of capture or start of a half)
// ST_RUN | draining the skid FIFO into the BRAM, one word per cycle
module pulse_buffer_writer #(
   parameter int ADDR_W     = 12,
   parameter int FIFO_DEPTH = 4,
   parameter int DROP_W     = 16
) (
   input  logic                 user_clk,
   input  logic                 user_rst_n,
   input  logic                 enable,
   pulse_buffer_writer_if.slave bus,
   output logic [31:0]          pulses_addr,
   output logic [DROP_W-1:0]    drop_count
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_OFF = 2'd0,
      ST_HDR = 2'd1,
      ST_RUN = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [27:0]       frame_cnt;
   logic [31:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_idx;
   logic [PTR_W-1:0]  wr_idx;
   logic [PTR_W:0]    fifo_cnt;

   logic              running;
   logic              fifo_empty;
   logic              fifo_full;
   logic              hdr_wr;
   logic              pop;
   logic              push;
   logic              drop;
   logic [ADDR_W-1:0] wr_ptr_nxt;
   logic [31:0]       in_word;

   function automatic logic [31:0] status_word(input logic en, input logic [ADDR_W-1:0] ptr);
      status_word             = '0;
      status_word[31]         = en;
      status_word[ADDR_W-1:0] = ptr;
   endfunction

   always_comb begin
      running    = enable && (state != ST_OFF);
      fifo_empty = (fifo_cnt == '0);
      fifo_full  = (fifo_cnt == FIFO_FULL);
      hdr_wr     = running && (state == ST_HDR);
      pop        = running && (state == ST_RUN) && !fifo_empty;
      // a pop in the same cycle frees a slot, so a full FIFO still accepts
      push       = running && bus.pulse_valid && (!fifo_full || pop);
      drop       = running && bus.pulse_valid && fifo_full && !pop;
      wr_ptr_nxt = wr_ptr + 1'b1;
      in_word    = {1'b0, bus.pulse_chan, bus.pulse_ts, bus.pulse_phase};
   end

   always_ff @(posedge user_clk) begin
      if (push) begin
         fifo_mem[wr_idx] <= in_word;
      end
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state         <= ST_OFF;
         wr_ptr        <= '0;
         frame_cnt     <= '0;
         rd_idx        <= '0;
         wr_idx        <= '0;
         fifo_cnt      <= '0;
         bus.bram_we   <= 1'b0;
         bus.bram_addr <= '0;
         bus.bram_din  <= '0;
         pulses_addr   <= '0;
         drop_count    <= '0;
      end else begin
         bus.bram_we <= 1'b0;

         if (!enable) begin
            state       <= ST_OFF;
            rd_idx      <= '0;
            wr_idx      <= '0;
            fifo_cnt    <= '0;
            pulses_addr <= status_word(1'b0, wr_ptr);
         end else if (state == ST_OFF) begin
            // capture start: new buffer pass opens with frame 0 at address 0
            state       <= ST_HDR;
            wr_ptr      <= '0;
            frame_cnt   <= '0;
            rd_idx      <= '0;
            wr_idx      <= '0;
            fifo_cnt    <= '0;
            pulses_addr <= status_word(1'b1, '0);
         end else begin
            if (hdr_wr) begin
               bus.bram_we   <= 1'b1;
               bus.bram_addr <= wr_ptr;
               bus.bram_din  <= {1'b1, 3'b010, frame_cnt};
               frame_cnt     <= frame_cnt + 1'b1;
            end else if (pop) begin
               bus.bram_we   <= 1'b1;
               bus.bram_addr <= wr_ptr;
               bus.bram_din  <= fifo_mem[rd_idx];
               rd_idx        <= rd_idx + 1'b1;
            end

            if (hdr_wr || pop) begin
               wr_ptr      <= wr_ptr_nxt;
               pulses_addr <= status_word(1'b1, wr_ptr_nxt);
               state       <= (wr_ptr_nxt[ADDR_W-2:0] == '0) ? ST_HDR : ST_RUN;
            end else begin
               pulses_addr <= status_word(1'b1, wr_ptr);
            end

            if (push) begin
               wr_idx <= wr_idx + 1'b1;
            end

            case ({push, pop})
               2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
               2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
               default: fifo_cnt <= fifo_cnt;
            endcase

            if (drop && !(&drop_count)) begin
               drop_count <= drop_count + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_pulse_buffer_writer.sv
// Bench for pulse_buffer_writer: a 12-bit-address instance checked against a write
// scoreboard, plus a 3-bit-address instance that reaches FIFO overflow quickly.
module tb_pulse_buffer_writer;
   localparam int AW   = 12;
   localparam int AW_S = 3;
   localparam int DW_S = 2;

   logic            user_clk   = 1'b0;
   logic            user_rst_n = 1'b0;
   logic            enable     = 1'b0;
   logic            enable_s   = 1'b0;
   logic [31:0]     pulses_addr;
   logic [31:0]     pulses_addr_s;
   logic [15:0]     drop_count;
   logic [DW_S-1:0] drop_count_s;

   pulse_buffer_writer_if #(.ADDR_W(AW))   bus ();
   pulse_buffer_writer_if #(.ADDR_W(AW_S)) bus_s ();

   pulse_buffer_writer #(.ADDR_W(AW), .FIFO_DEPTH(4), .DROP_W(16)) dut (
      .user_clk    (user_clk),
      .user_rst_n  (user_rst_n),
      .enable      (enable),
      .bus         (bus),
      .pulses_addr (pulses_addr),
      .drop_count  (drop_count)
   );

   pulse_buffer_writer #(.ADDR_W(AW_S), .FIFO_DEPTH(4), .DROP_W(DW_S)) dut_s (
      .user_clk    (user_clk),
      .user_rst_n  (user_rst_n),
      .enable      (enable_s),
      .bus         (bus_s),
      .pulses_addr (pulses_addr_s),
      .drop_count  (drop_count_s)
   );

   always #5 user_clk = ~user_clk;

   typedef struct {
      logic [8:0]  chan;
      logic [9:0]  ts;
      logic [11:0] phase;
      logic [31:0] word;
   } vec_t;

   vec_t        vecs [5];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q [$];
   logic [AW-1:0] exp_ptr   = '0;
   logic [27:0]   exp_frame = '0;
   int          hdr_seen = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // every big-instance write must land at the next address, header first in each half
   task automatic monitor();
      logic [31:0] want;
      if (bus.bram_we === 1'b1) begin
         check32("bram_addr", {20'b0, bus.bram_addr}, {20'b0, exp_ptr});
         if (exp_ptr[AW-2:0] == '0) begin
            want = {4'b1010, exp_frame};
            exp_frame++;
            hdr_seen++;
            check32("bram_din", bus.bram_din, want);
         end else if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bram_din: got unexpected write 0x%08h, expected no write", bus.bram_din);
         end else begin
            want = exp_q.pop_front();
            check32("bram_din", bus.bram_din, want);
         end
         exp_ptr++;
         check32("pulses_addr", pulses_addr, {1'b1, 19'b0, exp_ptr});
      end
   endtask

   task automatic step();
      @(posedge user_clk);
      #1;
      monitor();
   endtask

   task automatic drive_pulse(input logic [8:0] chan, input logic [9:0] ts, input logic [11:0] phase);
      bus.pulse_valid = 1'b1;
      bus.pulse_chan  = chan;
      bus.pulse_ts    = ts;
      bus.pulse_phase = phase;
      exp_q.push_back({1'b0, chan, ts, phase});
   endtask

   initial begin
      vecs[0] = '{chan: 9'd5,     ts: 10'h3FF, phase: 12'h123, word: 32'h017F_F123};
      vecs[1] = '{chan: 9'h1FF,   ts: 10'h000, phase: 12'h000, word: 32'h7FC0_0000};
      vecs[2] = '{chan: 9'h000,   ts: 10'h3FF, phase: 12'hFFF, word: 32'h003F_FFFF};
      vecs[3] = '{chan: 9'h0AA,   ts: 10'h155, phase: 12'hABC, word: 32'h2A95_5ABC};
      vecs[4] = '{chan: 9'h000,   ts: 10'h000, phase: 12'h000, word: 32'h0000_0000};

      bus.pulse_valid   = 1'b0;
      bus.pulse_chan    = '0;
      bus.pulse_ts      = '0;
      bus.pulse_phase   = '0;
      bus_s.pulse_valid = 1'b0;
      bus_s.pulse_chan  = '0;
      bus_s.pulse_ts    = '0;
      bus_s.pulse_phase = '0;

      #2;
      check32("rst_bram_we",     {31'b0, bus.bram_we}, 32'h0);
      check32("rst_bram_addr",   {20'b0, bus.bram_addr}, 32'h0);
      check32("rst_bram_din",    bus.bram_din, 32'h0);
      check32("rst_pulses_addr", pulses_addr, 32'h0);
      check32("rst_drop_count",  {16'b0, drop_count}, 32'h0);
      check32("rst_drop_s",      {30'b0, drop_count_s}, 32'h0);

      @(posedge user_clk);
      #1;
      user_rst_n = 1'b1;
      step();
      check32("idle_we", {31'b0, bus.bram_we}, 32'h0);

      // capture start with no pulses: a single header then silence
      enable    = 1'b1;
      exp_ptr   = '0;
      exp_frame = '0;
      step();
      check32("en_edge_pulses_addr", pulses_addr, 32'h8000_0000);
      check32("en_edge_we", {31'b0, bus.bram_we}, 32'h0);
      step();
      check32("hdr0_we",  {31'b0, bus.bram_we}, 32'h1);
      check32("hdr0_din", bus.bram_din, 32'hA000_0000);
      check32("hdr0_pulses_addr", pulses_addr, 32'h8000_0001);
      step();
      check32("after_hdr_we", {31'b0, bus.bram_we}, 32'h0);

      // isolated pulses: word appears one edge after it is sampled
      for (int i = 0; i < 5; i++) begin
         drive_pulse(vecs[i].chan, vecs[i].ts, vecs[i].phase);
         step();
         check32("pulse_not_early", {31'b0, bus.bram_we}, 32'h0);
         bus.pulse_valid = 1'b0;
         step();
         check32("pulse_we",  {31'b0, bus.bram_we}, 32'h1);
         check32("pulse_din", bus.bram_din, vecs[i].word);
         if (i == 0) check32("pulse0_pulses_addr", pulses_addr, 32'h8000_0002);
      end

      // back-to-back stream across the half boundary and the buffer wrap
      for (int i = 0; i < 4200; i++) begin
         drive_pulse(9'($urandom), 10'($urandom), 12'($urandom));
         step();
      end
      check32("stream_drops", {16'b0, drop_count}, 32'h0);
      check32("stream_headers", 32'(hdr_seen), 32'd3);

      // disable with the stream still running: FIFO contents are discarded
      bus.pulse_valid = 1'b0;
      enable          = 1'b0;
      step();
      check32("dis_we", {31'b0, bus.bram_we}, 32'h0);
      check32("dis_pulses_addr", pulses_addr, 32'h0000_006D);
      check32("fifo_words_lost", 32'(exp_q.size()), 32'd3);
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         step();
         check32("dis_hold_we", {31'b0, bus.bram_we}, 32'h0);
         check32("dis_hold_ptr", pulses_addr, 32'h0000_006D);
      end

      // re-enable restarts at address 0 with frame 0
      enable    = 1'b1;
      exp_ptr   = '0;
      exp_frame = '0;
      step();
      check32("reen_pulses_addr", pulses_addr, 32'h8000_0000);
      step();
      check32("reen_we",  {31'b0, bus.bram_we}, 32'h1);
      check32("reen_din", bus.bram_din, 32'hA000_0000);
      check32("reen_addr", {20'b0, bus.bram_addr}, 32'h0);
      drive_pulse(9'd7, 10'd9, 12'd11);
      step();
      bus.pulse_valid = 1'b0;
      step();
      check32("reen_pulse_din", bus.bram_din, 32'h01C0_900B);
      step();
      check32("queue_drained", 32'(exp_q.size()), 32'd0);

      // small instance: a header every 4 words fills the FIFO, then drops saturate
      enable_s = 1'b1;
      step();
      bus_s.pulse_valid = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         bus_s.pulse_chan  = 9'($urandom);
         bus_s.pulse_ts    = 10'($urandom);
         bus_s.pulse_phase = 12'($urandom);
         step();
         case (e)
            1: begin
               check32("s_hdr0_din",  bus_s.bram_din, 32'hA000_0000);
               check32("s_hdr0_addr", {29'b0, bus_s.bram_addr}, 32'h0);
            end
            5: begin
               check32("s_hdr1_din",  bus_s.bram_din, 32'hA000_0001);
               check32("s_hdr1_addr", {29'b0, bus_s.bram_addr}, 32'h4);
            end
            9: begin
               check32("s_wrap_din",  bus_s.bram_din, 32'hA000_0002);
               check32("s_wrap_addr", {29'b0, bus_s.bram_addr}, 32'h0);
               check32("s_wrap_pulses_addr", pulses_addr_s, 32'h8000_0001);
            end
            16: check32("s_full_pop_no_drop", {30'b0, drop_count_s}, 32'd0);
            17: check32("s_drop1", {30'b0, drop_count_s}, 32'd1);
            21: check32("s_drop2", {30'b0, drop_count_s}, 32'd2);
            25: check32("s_drop3", {30'b0, drop_count_s}, 32'd3);
            30: check32("s_drop_sat", {30'b0, drop_count_s}, 32'd3);
            default: ;
         endcase
      end
      bus_s.pulse_valid = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
